// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count done pulse
// and optional auto-reload for periodic ticks.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;

  logic             do_load;
  logic             tick;
  logic             at_term;
  logic             tick_term;
  logic             tick_dec;

  // Mutually exclusive action selects: clear > load > decrement.
  assign do_load   = load & ~clear;
  assign tick      = (state_q == RUN) & enable
                   & ~clear & ~load;
  assign at_term   = (count_q == WIDTH'(1));
  assign tick_term = tick & at_term;
  assign tick_dec  = tick & ~at_term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (1'b1)
      clear: begin
        count_d = '0;
        state_d = IDLE;
      end
      do_load: begin
        count_d  = load_value;
        reload_d = load_value;
        state_d  = (load_value != '0) ? RUN : IDLE;
      end
      tick_term: begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      tick_dec: begin
        count_d = count_q - WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes
// expected post-edge outputs, a monitor pops and compares.
module tb_countdown_timer;

  typedef struct {
    logic [7:0] count;
    logic       zero;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [7:0] count;
  logic       zero;
  logic       busy;
  logic       done;

  exp_t q[$];
  int   checks;
  int   errors;

  countdown_timer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".count"}, int'(count), int'(e.count));
    chk({tag, ".zero"},  int'(zero),  int'(e.zero));
    chk({tag, ".busy"},  int'(busy),  int'(e.busy));
    chk({tag, ".done"},  int'(done),  int'(e.done));
  endtask

  // Monitor: outputs settled mid-cycle are compared here.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk_all($sformatf("t%0t", $time), e);
    end
  end

  // One clock edge with the given inputs; expectations are
  // the outputs visible after that edge.
  task automatic step(input logic c, input logic l,
                      input logic [7:0] lv,
                      input logic en, input logic ar,
                      input logic [7:0] ec,
                      input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    clear       = c;
    load        = l;
    load_value  = lv;
    enable      = en;
    auto_reload = ar;
    @(posedge clk);
    #1;
    e.count = ec;
    e.zero  = (ec == 8'd0);
    e.busy  = eb;
    e.done  = ed;
    q.push_back(e);
  endtask

  task automatic run(input logic en, input logic ar,
                     input logic [7:0] ec,
                     input logic eb, input logic ed);
    step(1'b0, 1'b0, 8'd0, en, ar, ec, eb, ed);
  endtask

  task automatic ld(input logic [7:0] v, input logic ar,
                    input logic eb);
    step(1'b0, 1'b1, v, 1'b1, ar, v, eb, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    exp_t r;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    clear       = 1'b0;
    load        = 1'b0;
    load_value  = 8'd0;
    enable      = 1'b0;
    auto_reload = 1'b0;
    r.count = 8'd0;
    r.zero  = 1'b1;
    r.busy  = 1'b0;
    r.done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", r);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset ignores enable.
    repeat (10) run(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // One-shot countdown from 5.
    ld(8'd5, 1'b0, 1'b1);
    run(1'b1, 1'b0, 8'd4, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // Auto-reload period 3.
    ld(8'd3, 1'b1, 1'b1);
    run(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
    run(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1,
         8'd0, 1'b0, 1'b0);

    // Enable gaps stretch the count.
    ld(8'd4, 1'b0, 1'b1);
    run(1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    run(1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
    run(1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    run(1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    // Load wins on the terminal edge.
    ld(8'd2, 1'b0, 1'b1);
    run(1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    ld(8'd9, 1'b0, 1'b1);
    run(1'b0, 1'b0, 8'd9, 1'b1, 1'b0);

    // Clear beats load.
    step(1'b1, 1'b1, 8'd7, 1'b1, 1'b0,
         8'd0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // Load of zero stays idle.
    ld(8'd0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

    // Clear on the terminal edge suppresses done.
    ld(8'd1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1,
         8'd0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // Reload of 1: done every enabled cycle.
    ld(8'd1, 1'b1, 1'b1);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
    run(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b1);

    // Max load value, partial countdown.
    ld(8'd255, 1'b0, 1'b1);
    run(1'b1, 1'b0, 8'd254, 1'b1, 1'b0);

    // Async reset between edges while running at 200.
    ld(8'd200, 1'b0, 1'b1);
    run(1'b0, 1'b0, 8'd200, 1'b1, 1'b0);
    drain();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", r);
    @(negedge clk);
    reset = 1'b1;
    run(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    ld(8'd2, 1'b1, 1'b1);
    run(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 8'd2, 1'b1, 1'b1);

    drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with terminal-count detection, the decrementing counterpart to the design's free-running 8-bit up-counter. Software/control logic loads a start value. The block then counts down one step per enabled cycle and flags expiry with a one-cycle `done` pulse. An optional auto-reload mode turns it into a periodic tick generator for the surrounding control logic.

## Interface
- `WIDTH`, 8, bit width of counter, load value and reload register (minimum 2).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when low, released when high.
- `clear`  in  1  synchronous abort: count to 0, state to IDLE.
- `load`  in  1  synchronous load strobe.
- `load_value`  in  WIDTH  start value captured on `load`.
- `enable`  in  1  decrement qualifier in RUN; ignored in IDLE.
- `auto_reload`  in  1  sampled at terminal count: 1 = reload and keep running, 0 = stop.
- `count`  out  WIDTH  current counter register.
- `zero`  out  1  combinational `count == 0`.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  registered one-cycle expiry pulse.

## Operation
- Internal regs: `count`, `reload_reg` (WIDTH), `state` (IDLE/RUN), `done`.
- Reset (reset low, async): `count`=0, `reload_reg`=0, state IDLE, `done`=0. Outputs: `zero`=1, `busy`=0.
- Per-edge priority: clear > load > decrement. Exactly one action per edge.
- `clear`: `count`<=0, state<=IDLE, `done`<=0. `reload_reg` unchanged.
- `load`, any state:
  - `count`<=`load_value` and `reload_reg`<=`load_value`.
  - state<=RUN if `load_value`!=0, else IDLE.
  - `done`<=0.
- IDLE: `count` holds and `enable` is ignored. Only `load` leaves IDLE.
- RUN, `enable`=0: everything holds; `done`<=0.
- RUN, `enable`=1, `count`>1: `count`<=`count`-1; `done`<=0.
- RUN, `enable`=1, `count`==1 (terminal):
  - `done`<=1 in all cases.
  - If `auto_reload`=1: `count`<=`reload_reg`, state stays RUN.
  - If `auto_reload`=0: `count`<=0, state<=IDLE.
- No wrap-around: `count` never decrements from 0. In RUN, `count`==0 is unreachable.
- `done` is never high on two consecutive cycles unless `reload_reg`==1 with auto-reload. In that case it is high every enabled cycle.
- Arithmetic is unsigned modulo 2^WIDTH. The maximum load is 2^WIDTH-1 (255 at default).

## Timing
- Load latency: `load` sampled at edge k gives `count`=`load_value` and `busy`=1 after edge k.
- Expiry: after load value N, the Nth enabled edge in RUN sets `done`=1 for exactly the following cycle.
  - Without auto-reload, `count`=0, `zero`=1 and `busy`=0 in that same cycle.
- Auto-reload period: N enabled cycles per `done` pulse.
- `enable` gaps stretch the countdown cycle-for-cycle; no decrement is lost or doubled.
- `load` on the terminal edge: load wins and no `done` is produced.
- `clear` on the terminal edge: no `done` is produced.
- `auto_reload` changes are only observed at the terminal edge.
- Reset mid-run: outputs go to reset values immediately, without waiting for `clk`. The first edge after release behaves as in IDLE.

## Test plan
- Reset held low, then released with no stimulus -> `count`=0, `zero`=1, `busy`=0, `done`=0. Values hold for 10 cycles even with `enable`=1.
- `load` 5, `enable`=1 continuously, `auto_reload`=0 -> `count` 5,4,3,2,1,0.
  - `done` high only in the cycle `count` first reads 0; `busy` falls in that same cycle.
  - `count` stays 0 afterwards.
- `load` 3 with `auto_reload`=1 -> `count` 3,2,1,3,2,1,3. `done` pulses in each cycle `count` shows the reloaded 3; `busy` stays 1.
- `load` 4, `enable` pattern 1,0,0,1,1,0,1 -> `count` 4,3,3,3,2,1,1,0. One `done` pulse, in the final cycle.
- Priority cases:
  - `load` 9 on the same edge as terminal (`count`=1, `enable`=1) -> `count`=9, no `done`.
  - `clear`+`load` together -> `count`=0, IDLE.
  - `load` 0 -> IDLE, `zero`=1, no `done`.
- Async reset asserted between edges with `count`=200 in RUN -> `count`=0 and `busy`=0 before the next edge. `reload_reg` is 0, verified by a later auto-reload attempt.
